weight_load_sequencer: RTL and testbench

Single-clock controller that sequences one layer's weights through the weight memory. It issues DDR burst requests for whole 64-word groups and generates the write address for the 324-bit words leaving the width converter. Once the load is complete, it sweeps the read address over the resident 1296-bit words for a configurable number of passes, with `mac_ready` backpressure. It sits between the layer controller, the DDR read master and the WeightDRM write/read address ports.

---
 rtl/weight_load_sequencer_pkg.sv | 48 ++++
 rtl/weight_load_sequencer_if.sv | 24 ++
 rtl/weight_rd_sweeper.sv | 52 +++++
 rtl/weight_load_sequencer.sv | 173 +++++++++++++++++
 tb/tb_weight_load_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_load_sequencer_pkg.sv
// Shared constants, state encoding and config payload for the weight load sequencer.
// Group geometry is derived so one DDR burst carries exactly one group of DRM words.
package weight_load_sequencer_pkg;

    localparam int unsigned WR_ADDR_DEPTH  = 10;
    localparam int unsigned RD_ADDR_DEPTH  = 8;
    localparam int unsigned DDR_ADDR_WIDTH = 32;
    localparam int unsigned DDR_BEAT_BITS  = 256;
    localparam int unsigned WR_WORD_BITS   = 324;
    localparam int unsigned GROUP_WORDS    = 64;
    // 64 x 324-bit words = 81 x 256-bit beats = 2592 bytes per group
    localparam int unsigned BURST_BEATS    = (GROUP_WORDS * WR_WORD_BITS) / DDR_BEAT_BITS;
    localparam int unsigned BURST_BYTES    = BURST_BEATS * (DDR_BEAT_BITS / 8);
    localparam int unsigned MAX_GROUPS     = 16;

    localparam int unsigned GROUP_NUM_W    = 5;
    localparam int unsigned RD_NUM_W       = RD_ADDR_DEPTH + 1;
    localparam int unsigned PASS_W         = 16;
    localparam int unsigned BURST_LEN_W    = 8;
    localparam int unsigned WORD_IDX_W     = $clog2(GROUP_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_GRP,
        ST_READ,
        ST_DONE
    } wls_state_e;

    typedef struct packed {
        logic [DDR_ADDR_WIDTH-1:0] ddr_base;
        logic [GROUP_NUM_W-1:0]    group_num;
        logic [RD_NUM_W-1:0]       rd_num;
        logic [PASS_W-1:0]         rd_passes;
    } wls_cfg_t;

    function automatic logic [GROUP_NUM_W-1:0] sat_group_num(input logic [GROUP_NUM_W-1:0] n);
        return (n > GROUP_NUM_W'(MAX_GROUPS)) ? GROUP_NUM_W'(MAX_GROUPS) : n;
    endfunction

    function automatic logic [DDR_ADDR_WIDTH-1:0] group_addr(
        input logic [DDR_ADDR_WIDTH-1:0] base,
        input logic [GROUP_NUM_W-1:0]    grp
    );
        return base + DDR_ADDR_WIDTH'(grp) * DDR_ADDR_WIDTH'(BURST_BYTES);
    endfunction

endpackage

// File: rtl/weight_load_sequencer_if.sv
// DDR burst request channel between the sequencer (master) and the DDR read master (slave).
interface weight_load_sequencer_if;
    import weight_load_sequencer_pkg::*;

    logic                      ddr_rd_req;
    logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
    logic [BURST_LEN_W-1:0]    ddr_rd_len;
    logic                      ddr_rd_ack;

    modport master (
        output ddr_rd_req,
        output ddr_rd_addr,
        output ddr_rd_len,
        input  ddr_rd_ack
    );

    modport slave (
        input  ddr_rd_req,
        input  ddr_rd_addr,
        input  ddr_rd_len,
        output ddr_rd_ack
    );

endinterface

// File: rtl/weight_rd_sweeper.sv
// Read-address sweeper over the resident 1296-bit words: wraps every rd_num words,
// counts passes, stalls on mac_ready and delays rd_valid to match the 1-cycle DRM read.
module weight_rd_sweeper
    import weight_load_sequencer_pkg::*;
(
    input  logic                     sys_clk,
    input  logic                     rstn,
    input  logic                     active,
    input  logic                     mac_ready,
    input  logic [RD_NUM_W-1:0]      rd_num,
    input  logic [PASS_W-1:0]        rd_passes,
    output logic [RD_ADDR_DEPTH-1:0] addr_rd,
    output logic                     rd_valid,
    output logic                     pass_done_c
);

    logic [RD_ADDR_DEPTH-1:0] addr_q;
    logic [PASS_W-1:0]        pass_q;
    logic                     rd_valid_q;
    logic                     step_c;
    logic                     wrap_c;

    assign step_c      = active && mac_ready;
    assign wrap_c      = (RD_NUM_W'(addr_q) == (rd_num - RD_NUM_W'(1)));
    assign pass_done_c = step_c && wrap_c && (pass_q == (rd_passes - PASS_W'(1)));

    // Address and pass count rest at zero whenever the sweep is not active.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            pass_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= step_c;
            if (!active) begin
                addr_q <= '0;
                pass_q <= '0;
            end else if (step_c) begin
                if (wrap_c) begin
                    addr_q <= '0;
                    pass_q <= pass_q + PASS_W'(1);
                end else begin
                    addr_q <= addr_q + RD_ADDR_DEPTH'(1);
                end
            end
        end
    end

    assign addr_rd  = addr_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/weight_load_sequencer.sv
// Layer weight load controller: fetches whole groups from DDR into the WeightDRM,
// then sweeps the resident words for the configured number of read passes.
module weight_load_sequencer
    import weight_load_sequencer_pkg::*;
(
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic                       cfg_start,
    input  logic [DDR_ADDR_WIDTH-1:0]  cfg_ddr_base,
    input  logic [GROUP_NUM_W-1:0]     cfg_group_num,
    input  logic [RD_NUM_W-1:0]        cfg_rd_num,
    input  logic [PASS_W-1:0]          cfg_rd_passes,
    weight_load_sequencer_if.master    ddr,
    input  logic                       drm_wr_valid,
    output logic [WR_ADDR_DEPTH-1:0]   addr_wr,
    output logic [RD_ADDR_DEPTH-1:0]   addr_rd,
    output logic                       rd_valid,
    input  logic                       mac_ready,
    output logic                       busy,
    output logic                       load_done,
    output logic                       err_unexp_wr
);

    wls_state_e                state_q;
    wls_state_e                state_d;
    wls_cfg_t                  cfg_q;
    logic [GROUP_NUM_W-1:0]    grp_q;
    logic [WR_ADDR_DEPTH-1:0]  addr_wr_q;
    logic                      req_q;
    logic [DDR_ADDR_WIDTH-1:0] req_addr_q;
    logic                      busy_q;
    logic                      load_done_q;
    logic                      err_q;

    logic                      start_c;
    logic [GROUP_NUM_W-1:0]    start_grp_c;
    logic                      start_skip_c;
    logic                      cfg_skip_c;
    logic                      wr_accept_c;
    logic                      last_word_c;
    logic                      grp_last_c;
    logic                      pass_done_c;

    assign start_c      = cfg_start && (state_q == ST_IDLE);
    assign start_grp_c  = sat_group_num(cfg_group_num);
    assign start_skip_c = (cfg_rd_num == '0) || (cfg_rd_passes == '0);
    assign cfg_skip_c   = (cfg_q.rd_num == '0) || (cfg_q.rd_passes == '0);
    assign wr_accept_c  = drm_wr_valid && (state_q == ST_WAIT_GRP);
    // Groups are 64-aligned because addr_wr is cleared at load start.
    assign last_word_c  = wr_accept_c &&
                          (addr_wr_q[WORD_IDX_W-1:0] == WORD_IDX_W'(GROUP_WORDS - 1));
    assign grp_last_c   = ((grp_q + GROUP_NUM_W'(1)) == cfg_q.group_num);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    if (start_grp_c != '0) begin
                        state_d = ST_REQ;
                    end else if (start_skip_c) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_REQ: begin
                if (req_q && ddr.ddr_rd_ack) begin
                    state_d = ST_WAIT_GRP;
                end
            end
            ST_WAIT_GRP: begin
                if (last_word_c) begin
                    if (!grp_last_c) begin
                        state_d = ST_REQ;
                    end else if (cfg_skip_c) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (pass_done_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Config capture, group/write-address tracking and registered status outputs.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cfg_q       <= '0;
            grp_q       <= '0;
            addr_wr_q   <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (start_c) begin
                cfg_q.ddr_base  <= cfg_ddr_base;
                cfg_q.group_num <= start_grp_c;
                cfg_q.rd_num    <= cfg_rd_num;
                cfg_q.rd_passes <= cfg_rd_passes;
                if (start_grp_c != '0) begin
                    grp_q     <= '0;
                    addr_wr_q <= '0;
                end
            end
            if (wr_accept_c) begin
                addr_wr_q <= addr_wr_q + WR_ADDR_DEPTH'(1);
            end
            if (last_word_c) begin
                grp_q <= grp_q + GROUP_NUM_W'(1);
            end
            if (drm_wr_valid && (state_q != ST_WAIT_GRP)) begin
                err_q <= 1'b1;
            end
            busy_q      <= (state_d != ST_IDLE);
            load_done_q <= (state_d == ST_DONE);
        end
    end

    // Request rises one cycle into REQ with its address, and drops after the ack.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            req_q      <= 1'b0;
            req_addr_q <= '0;
        end else if ((state_q == ST_REQ) && !req_q) begin
            req_q      <= 1'b1;
            req_addr_q <= group_addr(cfg_q.ddr_base, grp_q);
        end else if (req_q && ddr.ddr_rd_ack) begin
            req_q <= 1'b0;
        end
    end

    weight_rd_sweeper u_rd_sweeper (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .active      (state_q == ST_READ),
        .mac_ready   (mac_ready),
        .rd_num      (cfg_q.rd_num),
        .rd_passes   (cfg_q.rd_passes),
        .addr_rd     (addr_rd),
        .rd_valid    (rd_valid),
        .pass_done_c (pass_done_c)
    );

    assign ddr.ddr_rd_req  = req_q;
    assign ddr.ddr_rd_addr = req_addr_q;
    assign ddr.ddr_rd_len  = BURST_LEN_W'(BURST_BEATS);
    assign addr_wr         = addr_wr_q;
    assign busy            = busy_q;
    assign load_done       = load_done_q;
    assign err_unexp_wr    = err_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Self-checking bench for weight_load_sequencer: table of load configurations driven with
// randomized ack/valid/ready timing, checked against a queue-based model of the expected traffic.
module tb_weight_load_sequencer;

    localparam int M_ALWAYS = 0;
    localparam int M_PAT    = 1;
    localparam int M_RAND   = 2;
    localparam int BYTES_PER_GROUP = 2592;

    typedef struct {
        logic [31:0] base;
        int          groups;
        int          rd_num;
        int          passes;
        int          mode;
        bit          early;
        bit          poke;
        int          ack_dly;
        int          exp_reqs;
        int          exp_reads;
        int          exp_wr_end;
    } vec_t;

    logic        sys_clk;
    logic        rstn;
    logic        cfg_start;
    logic [31:0] cfg_ddr_base;
    logic [4:0]  cfg_group_num;
    logic [8:0]  cfg_rd_num;
    logic [15:0] cfg_rd_passes;
    logic        drm_wr_valid;
    logic [9:0]  addr_wr;
    logic [7:0]  addr_rd;
    logic        rd_valid;
    logic        mac_ready;
    logic        busy;
    logic        load_done;
    logic        err_unexp_wr;

    int checks = 0;
    int errors = 0;

    weight_load_sequencer_if ddr_if ();

    weight_load_sequencer dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .cfg_start     (cfg_start),
        .cfg_ddr_base  (cfg_ddr_base),
        .cfg_group_num (cfg_group_num),
        .cfg_rd_num    (cfg_rd_num),
        .cfg_rd_passes (cfg_rd_passes),
        .ddr           (ddr_if),
        .drm_wr_valid  (drm_wr_valid),
        .addr_wr       (addr_wr),
        .addr_rd       (addr_rd),
        .rd_valid      (rd_valid),
        .mac_ready     (mac_ready),
        .busy          (busy),
        .load_done     (load_done),
        .err_unexp_wr  (err_unexp_wr)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},     32'(ddr_if.ddr_rd_req), 32'd0);
        check({tag, "_ddraddr"}, ddr_if.ddr_rd_addr,     32'd0);
        check({tag, "_len"},     32'(ddr_if.ddr_rd_len), 32'd81);
        check({tag, "_addr_wr"}, 32'(addr_wr),           32'd0);
        check({tag, "_addr_rd"}, 32'(addr_rd),           32'd0);
        check({tag, "_rd_valid"},32'(rd_valid),          32'd0);
        check({tag, "_busy"},    32'(busy),              32'd0);
        check({tag, "_done"},    32'(load_done),         32'd0);
        check({tag, "_err"},     32'(err_unexp_wr),      32'd0);
    endtask

    // Bounded wait for a DDR request, sampled on falling edges.
    task automatic wait_req(output bit seen);
        int n;
        n = 0;
        while (!ddr_if.ddr_rd_req && n < 8) begin
            @(negedge sys_clk);
            n++;
        end
        seen = ddr_if.ddr_rd_req;
    endtask

    task automatic run_vec(input vec_t v);
        int          g_eff;
        int          wr_k;
        int          n_reqs;
        int          n_reads;
        int          c;
        int          first_rv;
        int          dly;
        int          q[$];
        bit          seen;
        bit          done;
        bit          req_seen;
        bit          prev_ready;
        logic [7:0]  prev_addr;
        logic [31:0] exp_addr;
        bit          pat [4];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        g_eff = (v.groups > 16) ? 16 : v.groups;
        q = {};
        if (v.rd_num != 0 && v.passes != 0)
            for (int p = 0; p < v.passes; p++)
                for (int a = 0; a < v.rd_num; a++)
                    q.push_back(a);

        mac_ready     = 1'b0;
        cfg_ddr_base  = v.base;
        cfg_group_num = 5'(v.groups);
        cfg_rd_num    = 9'(v.rd_num);
        cfg_rd_passes = 16'(v.passes);
        cfg_start     = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        wr_k   = 0;
        n_reqs = 0;
        for (int g = 0; g < g_eff; g++) begin
            wait_req(seen);
            check("req_seen", 32'(seen), 32'd1);
            if (!seen) return;
            n_reqs++;
            exp_addr = v.base + 32'(g) * 32'(BYTES_PER_GROUP);
            check("req_addr", ddr_if.ddr_rd_addr, exp_addr);
            dly = (v.ack_dly < 0) ? int'($urandom_range(0, 3)) : v.ack_dly;
            repeat (dly) @(negedge sys_clk);
            check("req_hold", {31'd0, ddr_if.ddr_rd_req} ^ ddr_if.ddr_rd_addr, 32'd1 ^ exp_addr);
            ddr_if.ddr_rd_ack = 1'b1;
            @(negedge sys_clk);
            ddr_if.ddr_rd_ack = 1'b0;
            check("req_drop", 32'(ddr_if.ddr_rd_req), 32'd0);

            for (int w = 0; w < 64; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drm_wr_valid = 1'b0;
                    @(negedge sys_clk);
                end
                drm_wr_valid = 1'b1;
                check("addr_wr", 32'(addr_wr), 32'(wr_k % 1024));
                wr_k++;
                if (v.poke && g == 0 && w == 10) begin
                    cfg_start     = 1'b1;
                    cfg_group_num = 5'd0;
                    cfg_rd_num    = 9'd1;
                    cfg_rd_passes = 16'd1;
                    cfg_ddr_base  = 32'hDEAD_0000;
                end
                if (v.early && g == g_eff - 1 && w == 63) mac_ready = 1'b1;
                @(negedge sys_clk);
                cfg_start = 1'b0;
            end
            drm_wr_valid = 1'b0;
        end
        if (g_eff > 0) check("addr_wr_end", 32'(addr_wr), 32'(v.exp_wr_end));

        // Read phase: each rd_valid pairs with the address shown one cycle earlier.
        prev_ready = mac_ready;
        prev_addr  = 8'd0;
        n_reads    = 0;
        first_rv   = -1;
        done       = 1'b0;
        req_seen   = 1'b0;
        c          = 0;
        while (!done && c < 4000) begin
            if (ddr_if.ddr_rd_req) req_seen = 1'b1;
            if (rd_valid) begin
                if (first_rv < 0) first_rv = c;
                n_reads++;
                if (q.size() == 0) check("rd_extra", 32'd1, 32'd0);
                else               check("rd_addr", 32'(prev_addr), 32'(q.pop_front()));
            end
            if (!prev_ready) begin
                check("rd_gap",  32'(rd_valid), 32'd0);
                check("rd_hold", 32'(addr_rd),  32'(prev_addr));
            end
            if (load_done) begin
                done = 1'b1;
            end else begin
                case (v.mode)
                    M_ALWAYS: mac_ready = 1'b1;
                    M_PAT:    mac_ready = pat[c % 4];
                    default:  mac_ready = 1'($urandom_range(0, 1));
                endcase
                if (c == 0 && v.early) mac_ready = 1'b1;
                prev_ready = mac_ready;
                prev_addr  = addr_rd;
                @(negedge sys_clk);
                c++;
            end
        end
        mac_ready = 1'b0;
        check("done_seen",   32'(done),        32'd1);
        check("rd_missing",  32'(q.size()),    32'd0);
        check("rd_count",    32'(n_reads),     32'(v.exp_reads));
        check("req_count",   32'(n_reqs),      32'(v.exp_reqs));
        check("no_late_req", 32'(req_seen),    32'd0);
        check("rd_wrap",     32'(addr_rd),     32'd0);
        if (v.early) check("read_entry", 32'(first_rv), 32'd1);
        @(negedge sys_clk);
        check("done_pulse", 32'(load_done), 32'd0);
        check("idle_busy",  32'(busy),      32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        bit   seen;
        vec_t rec;

        vecs[0] = '{32'h0000_1000,  2,   4, 2, M_ALWAYS, 1'b0, 1'b0,  3,  2,   8, 128};
        vecs[1] = '{32'h0000_0000,  0, 256, 1, M_ALWAYS, 1'b0, 1'b0, -1,  0, 256,   0};
        vecs[2] = '{32'h2000_0000,  3,   5, 3, M_PAT,    1'b0, 1'b1, -1,  3,  15, 192};
        vecs[3] = '{32'hFFFF_F000, 16,   7, 2, M_RAND,   1'b1, 1'b0, -1, 16,  14,   0};
        vecs[4] = '{32'h0000_0040, 31,   1, 1, M_RAND,   1'b0, 1'b0, -1, 16,   1,   0};
        vecs[5] = '{32'h0000_0080,  1,   0, 5, M_RAND,   1'b0, 1'b0,  0,  1,   0,  64};
        vecs[6] = '{32'h0000_0000,  0,   3, 0, M_ALWAYS, 1'b0, 1'b0, -1,  0,   0,   0};
        vecs[7] = '{32'h0000_0123,  1, 256, 2, M_RAND,   1'b1, 1'b0, -1,  1, 512,  64};

        rstn              = 1'b0;
        cfg_start         = 1'b0;
        cfg_ddr_base      = 32'd0;
        cfg_group_num     = 5'd0;
        cfg_rd_num        = 9'd0;
        cfg_rd_passes     = 16'd0;
        drm_wr_valid      = 1'b0;
        mac_ready         = 1'b0;
        ddr_if.ddr_rd_ack = 1'b0;
        repeat (3) @(negedge sys_clk);
        rstn = 1'b1;
        @(negedge sys_clk);
        check_all_zero("reset");

        // Stray write strobe while idle
        drm_wr_valid = 1'b1;
        @(negedge sys_clk);
        drm_wr_valid = 1'b0;
        check("err_set",       32'(err_unexp_wr), 32'd1);
        check("err_addr_hold", 32'(addr_wr),      32'd0);
        check("err_not_busy",  32'(busy),         32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        check("err_sticky", 32'(err_unexp_wr), 32'd1);

        // Asynchronous reset in the middle of a group
        cfg_ddr_base  = 32'h0000_0500;
        cfg_group_num = 5'd1;
        cfg_rd_num    = 9'd2;
        cfg_rd_passes = 16'd1;
        cfg_start     = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        wait_req(seen);
        check("abort_req", 32'(seen), 32'd1);
        ddr_if.ddr_rd_ack = 1'b1;
        @(negedge sys_clk);
        ddr_if.ddr_rd_ack = 1'b0;
        repeat (5) begin
            drm_wr_valid = 1'b1;
            @(negedge sys_clk);
        end
        check("abort_pre_addr", 32'(addr_wr), 32'd5);
        check("abort_pre_busy", 32'(busy),    32'd1);
        #2 rstn = 1'b0;
        #1 check_all_zero("abort");
        drm_wr_valid = 1'b0;
        @(negedge sys_clk);
        rstn = 1'b1;
        @(negedge sys_clk);
        check_all_zero("post_abort");
        rec = '{32'h0000_0600, 1, 2, 1, M_ALWAYS, 1'b0, 1'b0, 1, 1, 2, 64};
        run_vec(rec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
